// File: rtl/preload_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | preload_sequencer_if                                                       |
// | Host stream, status and latency-buffer preload signals of the sequencer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface preload_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int CLAUSE_W = 32,
  parameter int PTR_W    = 16,
  parameter int ENG_W    = 2
);
  logic                start;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [CLAUSE_W-1:0] clause_out;
  logic                load_clause_out;
  logic [PTR_W-1:0]    ptr_out;
  logic                load_ptr_out;
  logic                load_change_engine_out;
  logic [ENG_W-1:0]    engine_idx_out;
  logic                busy;
  logic                done;
  logic                err_out;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, clause_out, load_clause_out, ptr_out, load_ptr_out,
           load_change_engine_out, engine_idx_out, busy, done, err_out
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, clause_out, load_clause_out, ptr_out, load_ptr_out,
           load_change_engine_out, engine_idx_out, busy, done, err_out
  );
endinterface
`default_nettype wire

// File: rtl/preload_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | preload_sequencer                                                          |
// | Splits a flat preprocessed image into per-engine clause/pointer preloads.  |
// | Optional macro PRELOAD_ERR_CHECK_EN: oversize headers abort with err_out.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module preload_sequencer #(
  parameter int NUM_ENGINE  = 4,
  parameter int DATA_W      = 32,
  parameter int CLAUSE_W    = 32,
  parameter int PTR_W       = 16,
  parameter int LIT_IDX_MAX = 8,
  parameter int CNT_W       = 16,
  parameter int MAX_CLAUSE  = 1024
) (
  input wire logic             clock,
  input wire logic             reset,
  preload_sequencer_if.slave   bus
);
  localparam int c_ENG_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int c_PCNT_W = $clog2(2 * LIT_IDX_MAX) + 1;
  localparam logic [c_PCNT_W-1:0] c_PTR_LAST = c_PCNT_W'(2 * LIT_IDX_MAX - 1);
  localparam logic [c_ENG_W-1:0]  c_ENG_LAST = c_ENG_W'(NUM_ENGINE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_CLAUSE = 3'd2,
    S_PTR    = 3'd3,
    S_CHG    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_clause_cnt;
  logic [c_PCNT_W-1:0] r_ptr_cnt;
  logic [c_ENG_W-1:0]  r_engine_idx;
  logic [CLAUSE_W-1:0] r_clause;
  logic                r_load_clause;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_load_ptr;
  logic                r_load_chg;

  logic                w_ready;
  logic                w_beat;
  logic [CNT_W-1:0]    w_hdr_cnt;
  logic                w_hdr_bad;

  assign w_ready   = (r_state == S_HDR) || (r_state == S_CLAUSE) || (r_state == S_PTR);
  assign w_beat    = bus.in_valid && w_ready;
  assign w_hdr_cnt = bus.in_data[CNT_W-1:0];

`ifdef PRELOAD_ERR_CHECK_EN
  logic r_err;
  assign w_hdr_bad   = (32'(w_hdr_cnt) > 32'(MAX_CLAUSE));
  assign bus.err_out = r_err;
`else
  assign w_hdr_bad   = 1'b0;
  assign bus.err_out = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_clause_cnt  <= '0;
      r_ptr_cnt     <= '0;
      r_engine_idx  <= '0;
      r_clause      <= '0;
      r_load_clause <= 1'b0;
      r_ptr         <= '0;
      r_load_ptr    <= 1'b0;
      r_load_chg    <= 1'b0;
`ifdef PRELOAD_ERR_CHECK_EN
      r_err         <= 1'b0;
`endif
    end else begin
      // Load strobes and their data are single-cycle; idle data reads as zero.
      r_load_clause <= 1'b0;
      r_load_ptr    <= 1'b0;
      r_load_chg    <= 1'b0;
      r_clause      <= '0;
      r_ptr         <= '0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state      <= S_HDR;
            r_engine_idx <= '0;
            r_clause_cnt <= '0;
            r_ptr_cnt    <= '0;
`ifdef PRELOAD_ERR_CHECK_EN
            r_err        <= 1'b0;
`endif
          end
        end
        S_HDR: begin
          if (w_beat) begin
            if (w_hdr_bad) begin
`ifdef PRELOAD_ERR_CHECK_EN
              r_err   <= 1'b1;
`endif
              r_state <= S_DONE;
            end else begin
              r_clause_cnt <= w_hdr_cnt;
              r_state      <= (w_hdr_cnt == '0) ? S_PTR : S_CLAUSE;
            end
          end
        end
        S_CLAUSE: begin
          if (w_beat) begin
            r_load_clause <= 1'b1;
            r_clause      <= bus.in_data[CLAUSE_W-1:0];
            r_clause_cnt  <= r_clause_cnt - CNT_W'(1);
            if (r_clause_cnt == CNT_W'(1)) begin
              r_state <= S_PTR;
            end
          end
        end
        S_PTR: begin
          if (w_beat) begin
            r_load_ptr <= 1'b1;
            r_ptr      <= bus.in_data[PTR_W-1:0];
            if (r_ptr_cnt == c_PTR_LAST) begin
              r_ptr_cnt <= '0;
              r_state   <= (r_engine_idx == c_ENG_LAST) ? S_DONE : S_CHG;
            end else begin
              r_ptr_cnt <= r_ptr_cnt + c_PCNT_W'(1);
            end
          end
        end
        S_CHG: begin
          // The change pulse lands after the last pointer pulse and before the
          // next engine's first clause, keeping the buffer indicators aligned.
          r_load_chg   <= 1'b1;
          r_engine_idx <= r_engine_idx + c_ENG_W'(1);
          r_state      <= S_HDR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready               = w_ready;
  assign bus.clause_out             = r_clause;
  assign bus.load_clause_out        = r_load_clause;
  assign bus.ptr_out                = r_ptr;
  assign bus.load_ptr_out           = r_load_ptr;
  assign bus.load_change_engine_out = r_load_chg;
  assign bus.engine_idx_out         = r_engine_idx;
  assign bus.busy                   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done                   = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_preload_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_preload_sequencer                                                       |
// | Randomised scoreboard bench: expected preload events come from the image.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_preload_sequencer;
  localparam int NE   = 2;
  localparam int LIM  = 2;
  localparam int MAXC = 1024;
  localparam int K_CL = 0, K_PTR = 1, K_CHG = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          eng;
  } ev_t;

  logic        clock;
  logic        reset;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] img_q[$];
  ev_t         exp_q[$];
  logic [31:0] exp_err;

  preload_sequencer_if #(.DATA_W(32), .CLAUSE_W(32), .PTR_W(16), .ENG_W(1)) intf ();

  preload_sequencer #(
    .NUM_ENGINE(NE), .DATA_W(32), .CLAUSE_W(32), .PTR_W(16),
    .LIT_IDX_MAX(LIM), .CNT_W(16), .MAX_CLAUSE(MAXC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(intf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: walk the image section by section and list the pulses it implies.
  task automatic build_expect();
    int p;
    int unsigned h;
    p = 0;
    exp_err = 0;
    exp_q.delete();
    for (int e = 0; e < NE; e++) begin
      if (e > 0) exp_q.push_back('{K_CHG, 32'd0, e});
      h = img_q[p] & 32'hFFFF;
      p++;
`ifdef PRELOAD_ERR_CHECK_EN
      if (h > MAXC) begin
        exp_err = 1;
        return;
      end
`endif
      for (int c = 0; c < int'(h); c++) begin
        exp_q.push_back('{K_CL, img_q[p], e});
        p++;
      end
      for (int k = 0; k < 2 * LIM; k++) begin
        exp_q.push_back('{K_PTR, img_q[p] & 32'hFFFF, e});
        p++;
      end
    end
  endtask

  task automatic gen_random();
    logic [31:0] w;
    int h;
    img_q.delete();
    for (int e = 0; e < NE; e++) begin
      h = $urandom_range(0, 5);
      w = $urandom;
      w[15:0] = 16'(h);
      img_q.push_back(w);
      for (int c = 0; c < h; c++) img_q.push_back($urandom);
      for (int k = 0; k < 2 * LIM; k++) img_q.push_back($urandom);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    intf.start = 1'b1;
    @(negedge clock);
    intf.start = 1'b0;
    #1;
    check("busy_after_start", 32'(intf.busy), 32'd1);
    check("done_after_start", 32'(intf.done), 32'd0);
  endtask

  // mode 0: valid always, 1: every other cycle, 2: random gaps.
  task automatic drive(input int mode, input int stop_at, input int start_at);
    int idx, cyc;
    bit v, x, sent;
    idx = 0;
    cyc = 0;
    sent = 0;
    while (idx < img_q.size() && idx != stop_at) begin
      @(negedge clock);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      intf.in_valid = v;
      intf.in_data  = v ? img_q[idx] : $urandom;
      intf.start    = (idx == start_at) && !sent;
      if (idx == start_at) sent = 1;
      x = v && intf.in_ready;
      @(posedge clock);
      if (x) idx++;
      cyc++;
      if (cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: accepted %0d of %0d words", idx, img_q.size());
        break;
      end
    end
    @(negedge clock);
    intf.in_valid = 1'b0;
    intf.start    = 1'b0;
  endtask

  task automatic finish_checks();
    int n;
    n = 0;
    while (!intf.done && n < 300) begin
      @(negedge clock);
      n++;
    end
    #1;
    check("done_end", 32'(intf.done), 32'd1);
    repeat (2) @(negedge clock);
    #1;
    check("events_drained", 32'(exp_q.size()), 32'd0);
    check("busy_end", 32'(intf.busy), 32'd0);
    check("in_ready_end", 32'(intf.in_ready), 32'd0);
    check("err_end", 32'(intf.err_out), exp_err);
    // Extra words after completion must be refused; the monitor flags any pulse.
    intf.in_valid = 1'b1;
    intf.in_data  = $urandom;
    repeat (3) @(negedge clock);
    intf.in_valid = 1'b0;
    #1;
    check("done_held", 32'(intf.done), 32'd1);
  endtask

  task automatic run(input int mode, input int start_at);
    build_expect();
    pulse_start();
    drive(mode, -1, start_at);
    finish_checks();
  endtask

  // Monitor: pops one expected event per load/change pulse.
  bit          hit;
  logic [31:0] mv;
  ev_t         me;
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if ((intf.load_clause_out && intf.load_ptr_out) ||
          (!intf.load_clause_out && intf.clause_out != '0) ||
          (!intf.load_ptr_out && intf.ptr_out != '0)) begin
        errors++;
        $display("FAIL load_exclusive: lc=%0b lp=%0b clause=%0h ptr=%0h, required one load at most and zero idle data",
                 intf.load_clause_out, intf.load_ptr_out, intf.clause_out, intf.ptr_out);
      end
      for (int k = 0; k < 3; k++) begin
        hit = (k == K_CL) ? intf.load_clause_out :
              (k == K_PTR) ? intf.load_ptr_out : intf.load_change_engine_out;
        mv  = (k == K_CL) ? intf.clause_out :
              (k == K_PTR) ? {16'd0, intf.ptr_out} : 32'd0;
        if (hit) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: kind=%0d val=%0h, required no pulse", k, mv);
          end else begin
            me = exp_q.pop_front();
            if (me.kind != k || me.val != mv || me.eng != int'(intf.engine_idx_out)) begin
              errors++;
              $display("FAIL event: got kind=%0d val=%0h eng=%0d, required kind=%0d val=%0h eng=%0d",
                       k, mv, intf.engine_idx_out, me.kind, me.val, me.eng);
            end
          end
        end
      end
    end
  end

  initial begin
    reset         = 1'b0;
    intf.start    = 1'b0;
    intf.in_valid = 1'b0;
    intf.in_data  = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_load_clause", 32'(intf.load_clause_out), 32'd0);
    check("rst_load_ptr", 32'(intf.load_ptr_out), 32'd0);
    check("rst_chg", 32'(intf.load_change_engine_out), 32'd0);
    check("rst_busy_done", {30'd0, intf.busy, intf.done}, 32'd0);
    check("rst_in_ready", 32'(intf.in_ready), 32'd0);
    check("rst_engine_idx", 32'(intf.engine_idx_out), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed image: two clauses for engine 0, one for engine 1.
    img_q = '{32'd2, 32'hC0C0_0000, 32'hC1C1_0001,
              32'hAAAA_1000, 32'hBBBB_1001, 32'hCCCC_1002, 32'hDDDD_1003,
              32'hFFFF_0001, 32'hC2C2_0002,
              32'h1111_2004, 32'h2222_2005, 32'h3333_2006, 32'h4444_2007};
    run(0, -1);
    run(1, -1);
    run(0, 5);

    // Zero-clause header for engine 0.
    img_q = '{32'd0, 32'h0000_3000, 32'h0000_3001, 32'h0000_3002, 32'h0000_3003,
              32'd1, 32'h5555_AAAA,
              32'h0000_4000, 32'h0000_4001, 32'h0000_4002, 32'h0000_4003};
    run(0, -1);

    // Asynchronous reset after the first clause beat.
    img_q = '{32'd2, 32'hC0C0_0000, 32'hC1C1_0001,
              32'hAAAA_1000, 32'hBBBB_1001, 32'hCCCC_1002, 32'hDDDD_1003,
              32'hFFFF_0001, 32'hC2C2_0002,
              32'h1111_2004, 32'h2222_2005, 32'h3333_2006, 32'h4444_2007};
    build_expect();
    pulse_start();
    drive(0, 2, -1);
    check("c0_before_reset", 32'(intf.load_clause_out), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_load_clause", 32'(intf.load_clause_out), 32'd0);
    check("abort_clause_data", intf.clause_out, 32'd0);
    check("abort_busy", 32'(intf.busy), 32'd0);
    check("abort_in_ready", 32'(intf.in_ready), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    run(0, -1);

    for (int t = 0; t < 6; t++) begin
      gen_random();
      run($urandom_range(0, 2), (t == 5) ? 3 : -1);
    end

`ifdef PRELOAD_ERR_CHECK_EN
    img_q = '{32'd1025};
    run(0, -1);
    img_q = '{32'd1, 32'h1234_5678, 32'd1, 32'd2, 32'd3, 32'd4, 32'd2000};
    run(0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/preload_sequencer.md
Name: preload_sequencer

Overview:
- Drives the preload port of the latency buffer: `clause_out`, `load_clause`, `ptr_out`, `load_ptr` and `load_change_engine`.
- Consumes a flat preprocessed image over a valid/ready stream and splits it into per-engine sections.
- Each section is one header word (the clause count), then that many clause words, then exactly 2*LIT_IDX_MAX pointer words.
- Inserts the engine-change pulse between sections so the buffer's engine indicators stay aligned, and reports busy/done/error status to the host.

Parameters:
- NUM_ENGINE, 4, number of engines loaded, in order 0..NUM_ENGINE-1.
- DATA_W, 32, stream word width; must be at least CLAUSE_W, PTR_W and CNT_W.
- CLAUSE_W, 32, width of a clause word (`node_t`).
- PTR_W, 16, width of a pointer entry (`dummy_entry_t`).
- LIT_IDX_MAX, 8, literal index bound; each engine receives 2*LIT_IDX_MAX pointer entries.
- CNT_W, 16, width of the clause-count field in the header.
- MAX_CLAUSE, 1024, largest legal clause count per engine; used only by the optional feature.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins a preload; honoured only in IDLE or DONE.
- in_data, input, DATA_W, stream word.
- in_valid, input, 1, stream word valid.
- in_ready, output, 1, sequencer accepts a word this cycle.
- clause_out, output, CLAUSE_W, clause to the buffer.
- load_clause_out, output, 1, clause_out valid.
- ptr_out, output, PTR_W, pointer entry to the buffer.
- load_ptr_out, output, 1, ptr_out valid.
- load_change_engine_out, output, 1, advance the buffer's clause engine indicator.
- engine_idx_out, output, $clog2(NUM_ENGINE), engine currently being loaded.
- busy, output, 1, a preload is in progress.
- done, output, 1, preload complete; held until the next start.
- err_out, output, 1, sticky header error.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset is asynchronous, so an assertion mid-preload aborts at once. No further pulses follow, and the buffer must be reset with it.
- A beat transfers when in_valid && in_ready. in_ready = 1 only in HDR, CLAUSE and PTR.
- FSM states: IDLE, HDR, CLAUSE, PTR, CHG, DONE.
  - IDLE or DONE + start: go to HDR; engine_idx = 0; done = 0; err_out = 0.
  - HDR, on a beat: clause_cnt = in_data[CNT_W-1:0]. If clause_cnt == 0 go to PTR, otherwise go to CLAUSE.
  - CLAUSE, per beat: emit the clause; decrement clause_cnt. On the beat where clause_cnt == 1, go to PTR.
  - PTR, per beat: emit in_data[PTR_W-1:0]; increment ptr_cnt (width $clog2(2*LIT_IDX_MAX)+1).
    - On the beat where ptr_cnt == 2*LIT_IDX_MAX-1: reset ptr_cnt to 0.
    - Then go to DONE if engine_idx == NUM_ENGINE-1, otherwise go to CHG.
  - CHG, exactly one cycle: load_change_engine_out = 1; engine_idx increments; in_ready = 0; go to HDR.
  - DONE: done = 1, busy = 0, hold until start.
- No change pulse is sent before engine 0 or after the last engine. The buffer's ptr indicator self-advances after 2*LIT_IDX_MAX entries, so no pulse is needed for pointers.
- Output timing:
  - Data and load outputs are registered: one cycle after the accepted beat.
  - load_clause_out and load_ptr_out are single-cycle pulses, at most one per cycle, never both high together.
  - clause_out and ptr_out are 0 whenever their load signal is low.
- busy = 1 in HDR, CLAUSE, PTR and CHG.
- Stall: while in_valid = 0 the state and counters hold and no load pulses are issued. Stalls may fall at any point, including between a header and its first clause.
- start while busy is ignored.
- Extra stream words after DONE are not accepted (in_ready = 0).

Optional Feature:
- Macro name: PRELOAD_ERR_CHECK_EN.
- Defined: a header with clause_cnt > MAX_CLAUSE sets err_out (sticky until the next start), emits nothing, and goes straight to DONE. The offending header word is consumed.
- Undefined: err_out is tied to 0 and the header is used as-is, truncated to CNT_W bits.

Test Plan:
- NUM_ENGINE=2, LIT_IDX_MAX=2. Stream {2, C0, C1, P0..P3, 1, C2, P4..P7}, in_valid held high:
  - C0 and C1 emitted on load_clause_out, then P0..P3 on load_ptr_out, each one cycle after its beat.
  - Exactly one load_change_engine_out pulse, between P3 and C2; no pulse before C0.
  - done = 1 after P7 completes; no change pulse after P7.
- Header 0 for engine 0: no clause pulses; the 4 pointer beats are accepted immediately; engine_idx = 0 until CHG.
- in_valid toggled every other cycle across the whole stream: the same output sequence as test 1 with gaps; no duplicated or dropped pulses.
- reset asserted after C0: all outputs 0 immediately. After release, start reloads from engine 0.
- start pulsed while busy in the middle of the stream: ignored; the sequence completes unchanged.
- With PRELOAD_ERR_CHECK_EN and header 1025 (MAX_CLAUSE=1024): err_out = 1, done = 1, no load pulses, in_ready = 0 afterwards.
